// File: rtl/rv32i_types.sv
// Shared RV32I types: funct3 encodings, port FSM state,
// byte-lane mask constants and request legality helper.
package rv32i_types;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mpu_state_t;

  typedef logic [3:0] rv32i_mem_wmask;

  localparam rv32i_mem_wmask MASK_B = 4'b0001;
  localparam rv32i_mem_wmask MASK_H = 4'b0011;
  localparam rv32i_mem_wmask MASK_W = 4'b1111;

  // Defined funct3 for the direction and naturally aligned.
  function automatic logic req_ok(
    input logic       is_wr,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic defd;
    logic aligned;
    if (is_wr) defd = (f3 <= 3'b010);
    else defd = (f3 != 3'b011) && (f3[2:1] != 2'b11);
    aligned = 1'b1;
    unique case (1'b1)
      (f3[1:0] == 2'b01): aligned = !off[0];
      (f3[1:0] == 2'b10): aligned = (off == 2'b00);
      default: ;
    endcase
    return defd && aligned;
  endfunction

endpackage

// File: rtl/mem_port_unit_if.sv
// Physical memory bus between the port unit and
// memory: held strobes completed by pmem_resp.
interface mem_port_unit_if;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;

  modport master (
    output pmem_read,
    output pmem_write,
    output pmem_address,
    output pmem_wdata,
    output pmem_byte_enable,
    input  pmem_rdata,
    input  pmem_resp
  );

  modport slave (
    input  pmem_read,
    input  pmem_write,
    input  pmem_address,
    input  pmem_wdata,
    input  pmem_byte_enable,
    output pmem_rdata,
    output pmem_resp
  );
endinterface

// File: rtl/mem_align.sv
// Byte-lane mask, store data shift and load
// lane extraction with sign/zero extension.
module mem_align
  import rv32i_types::*;
(
  input  logic [1:0]     wr_off,
  input  logic [1:0]     wr_size,
  input  logic [31:0]    wdata,
  input  logic [1:0]     rd_off,
  input  logic [2:0]     rd_funct3,
  input  logic [31:0]    rd_word,
  output rv32i_mem_wmask lane_mask,
  output logic [31:0]    wdata_sh,
  output logic [31:0]    rdata_ext
);

  logic [31:0] rd_sh;

  assign wdata_sh = wdata << {wr_off, 3'b000};
  assign rd_sh    = rd_word >> {rd_off, 3'b000};

  always_comb begin
    lane_mask = MASK_W;
    unique case (1'b1)
      (wr_size == 2'b00): lane_mask = MASK_B << wr_off;
      (wr_size == 2'b01): lane_mask = MASK_H << wr_off;
      default: ;
    endcase
  end

  always_comb begin
    rdata_ext = rd_sh;
    unique case (rd_funct3)
      lb:  rdata_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
      lh:  rdata_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
      lbu: rdata_ext = {24'd0, rd_sh[7:0]};
      lhu: rdata_ext = {16'd0, rd_sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_unit.sv
// Load/store port: one word-aligned pmem access per
// core request, with misalignment and timeout errors.
module mem_port_unit
  import rv32i_types::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_funct3,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  mem_port_unit_if.master pmem
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT_CYCLES - 1);

  mpu_state_t     state;
  logic           is_wr_q;
  logic [1:0]     off_q;
  logic [2:0]     f3_q;
  rv32i_mem_wmask mask_q;
  logic [CW-1:0]  cnt_q;

  rv32i_mem_wmask lane_mask;
  logic [31:0]    wdata_sh;
  logic [31:0]    rdata_ext;
  logic           req;

  assign req = mem_read || mem_write;

  mem_align u_align (
    .wr_off    (mem_address[1:0]),
    .wr_size   (mem_funct3[1:0]),
    .wdata     (mem_wdata),
    .rd_off    (off_q),
    .rd_funct3 (f3_q),
    .rd_word   (pmem.pmem_rdata),
    .lane_mask (lane_mask),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      is_wr_q               <= 1'b0;
      off_q                 <= 2'b00;
      f3_q                  <= 3'b000;
      mask_q                <= '0;
      cnt_q                 <= '0;
      mem_rdata             <= '0;
      mem_resp              <= 1'b0;
      mem_err               <= 1'b0;
      rmask                 <= '0;
      wmask                 <= '0;
      pmem.pmem_read        <= 1'b0;
      pmem.pmem_write       <= 1'b0;
      pmem.pmem_address     <= '0;
      pmem.pmem_wdata       <= '0;
      pmem.pmem_byte_enable <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            is_wr_q <= mem_write;
            off_q   <= mem_address[1:0];
            f3_q    <= mem_funct3;
            mask_q  <= lane_mask;
            if (req_ok(mem_write, mem_funct3,
                       mem_address[1:0])) begin
              state             <= REQ;
              cnt_q             <= '0;
              pmem.pmem_read    <= !mem_write;
              pmem.pmem_write   <= mem_write;
              pmem.pmem_address <=
                {mem_address[31:2], 2'b00};
              pmem.pmem_wdata   <= wdata_sh;
              pmem.pmem_byte_enable <=
                mem_write ? lane_mask : MASK_W;
            end else begin
              state    <= DONE;
              mem_resp <= 1'b1;
              mem_err  <= 1'b1;
            end
          end
        end
        REQ: begin
          if (pmem.pmem_resp) begin
            state           <= DONE;
            mem_resp        <= 1'b1;
            pmem.pmem_read  <= 1'b0;
            pmem.pmem_write <= 1'b0;
            if (is_wr_q) begin
              wmask <= mask_q;
            end else begin
              rmask     <= mask_q;
              mem_rdata <= rdata_ext;
            end
          end else if (cnt_q == LAST) begin
            state           <= DONE;
            mem_resp        <= 1'b1;
            mem_err         <= 1'b1;
            pmem.pmem_read  <= 1'b0;
            pmem.pmem_write <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          mem_resp  <= 1'b0;
          mem_err   <= 1'b0;
          mem_rdata <= '0;
          rmask     <= '0;
          wmask     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_unit.sv
// Scoreboard bench for mem_port_unit: byte-level memory
// model, randomized requests and directed corner cases.
module tb_mem_port_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_wdata = '0;
  logic [2:0]  mem_funct3 = '0;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;
  logic [3:0]  rmask;
  logic [3:0]  wmask;

  mem_port_unit_if p ();

  mem_port_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_funct3  (mem_funct3),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .mem_err     (mem_err),
    .rmask       (rmask),
    .wmask       (wmask),
    .pmem        (p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [31:0] pm [64];
  logic [7:0]  ref_mem [256];

  logic [31:0] exp_waddr = '0;
  logic [31:0] exp_pwdata = '0;
  logic        exp_is_wr = 1'b0;
  logic [3:0]  exp_be = '0;
  int          rsp_dly = -1;
  bit          no_resp = 1'b0;
  bit          stray_req = 1'b0;
  int          strobe_cycles = 0;
  int          first_strobe_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic preload(input logic [31:0] a,
                         input logic [31:0] w);
    pm[a[7:2]] = w;
    for (int i = 0; i < 4; i++)
      ref_mem[{a[7:2], 2'(i)}] = w[8*i +: 8];
  endtask

  // Access size in bytes, 0 for an undefined funct3.
  function automatic int fsize(input logic [2:0] f3,
                               input logic wr);
    int s;
    s = 0;
    case (f3)
      3'd0: s = 1;
      3'd1: s = 2;
      3'd2: s = 4;
      3'd4: s = wr ? 0 : 1;
      3'd5: s = wr ? 0 : 2;
      default: s = 0;
    endcase
    return s;
  endfunction

  // Physical memory: random or fixed delay per access.
  initial begin : responder
    bit active;
    int dly;
    logic [5:0] idx;
    active = 1'b0;
    dly = 0;
    p.pmem_resp = 1'b0;
    p.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      p.pmem_resp = 1'b0;
      if (!rst && (p.pmem_read || p.pmem_write)) begin
        strobe_cycles++;
        idx = p.pmem_address[7:2];
        if (!active) begin
          active = 1'b1;
          first_strobe_cyc = cyc;
          dly = (rsp_dly < 0) ? $urandom_range(0, 3)
                              : rsp_dly;
          chk("pmem_address", 128'(p.pmem_address),
              128'(exp_waddr));
          chk("pmem_dir", 128'({p.pmem_write, p.pmem_read}),
              128'({exp_is_wr, !exp_is_wr}));
          chk("pmem_byte_enable", 128'(p.pmem_byte_enable),
              128'(exp_be));
          if (exp_is_wr)
            chk("pmem_wdata", 128'(p.pmem_wdata),
                128'(exp_pwdata));
        end
        if (!no_resp) begin
          if (dly == 0) begin
            p.pmem_resp = 1'b1;
            if (p.pmem_write) begin
              for (int i = 0; i < 4; i++)
                if (p.pmem_byte_enable[i])
                  pm[idx][8*i +: 8] = p.pmem_wdata[8*i +: 8];
              p.pmem_rdata = $urandom;
            end else begin
              p.pmem_rdata = pm[idx];
            end
            active = 1'b0;
          end else begin
            dly--;
          end
        end
      end else begin
        active = 1'b0;
        if (stray_req) begin
          p.pmem_resp = 1'b1;
          p.pmem_rdata = $urandom;
          stray_req = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && mem_resp) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 128'(mem_resp), 128'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("mem_err", 128'(mem_err), 128'(mon_e.err));
          chk("rmask", 128'(rmask), 128'(mon_e.rmask));
          chk("wmask", 128'(wmask), 128'(mon_e.wmask));
          if (mon_e.is_load && !mon_e.err)
            chk("mem_rdata", 128'(mem_rdata),
                128'(mon_e.rdata));
        end
      end
    end
  end

  task automatic do_req(input logic rd,
                        input logic wr,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic [2:0] f3,
                        input int dly,
                        input int exp_lat);
    exp_t e;
    int sz;
    bit legal;
    logic [3:0] mask;
    logic [31:0] v;
    int lat;
    int issue;
    sz = fsize(f3, wr);
    legal = (sz != 0) && ((addr % sz) == 0);
    mask = '0;
    e.is_load = !wr;
    e.err = !legal;
    e.rdata = '0;
    e.rmask = '0;
    e.wmask = '0;
    if (legal) begin
      mask = 4'(((1 << sz) - 1) << (addr % 4));
      if (wr) begin
        e.wmask = mask;
      end else begin
        e.rmask = mask;
        v = '0;
        for (int i = 0; i < sz; i++)
          v = v | (32'(ref_mem[8'(addr + i)]) << (8 * i));
        if (!f3[2] && sz < 4 &&
            v >= (32'd1 << (8 * sz - 1)))
          v = v - (32'd1 << (8 * sz));
        e.rdata = v;
      end
      if (no_resp) begin
        e.err = 1'b1;
        e.rmask = '0;
        e.wmask = '0;
      end
    end
    exp_q.push_back(e);
    exp_waddr = addr & ~32'd3;
    exp_is_wr = wr;
    exp_be = wr ? mask : 4'hf;
    exp_pwdata = wdata << (8 * (addr % 4));
    rsp_dly = dly;
    strobe_cycles = 0;
    first_strobe_cyc = -1;
    @(posedge clk);
    #1;
    issue = cyc;
    mem_read = rd;
    mem_write = wr;
    mem_address = addr;
    mem_wdata = wdata;
    mem_funct3 = f3;
    lat = 0;
    for (int n = 1; n <= 200 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (mem_resp) lat = n;
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    if (lat == 0)
      chk("resp_wait", 128'(mem_resp), 128'(1));
    if (exp_lat >= 0)
      chk("latency", 128'(lat), 128'(exp_lat));
    if (legal)
      chk("strobe_start", 128'(first_strobe_cyc),
          128'(issue + 1));
    else
      chk("no_pmem_access", 128'(strobe_cycles), 128'(0));
    if (legal && wr && !no_resp)
      for (int i = 0; i < sz; i++)
        ref_mem[8'(addr + i)] = wdata[8*i +: 8];
  endtask

  initial begin : stim
    int kind;
    for (int i = 0; i < 64; i++)
      preload(32'(i * 4), $urandom);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        128'({mem_resp, mem_err, mem_rdata, rmask, wmask,
              p.pmem_read, p.pmem_write, p.pmem_address,
              p.pmem_wdata, p.pmem_byte_enable}),
        128'(0));
    rst = 1'b0;

    preload(32'h100, 32'h80FF_1234);
    do_req(1, 0, 32'h103, 32'h0, 3'b000, 1, 3);
    do_req(0, 1, 32'h202, 32'h0000_ABCD, 3'b001, 0, 2);
    preload(32'h100, 32'h8001_0000);
    do_req(1, 0, 32'h102, 32'h0, 3'b101, -1, -1);
    do_req(1, 0, 32'h101, 32'h0, 3'b010, -1, 1);
    do_req(1, 0, 32'h104, 32'h0, 3'b011, -1, 1);
    do_req(0, 1, 32'h104, 32'h5, 3'b100, -1, 1);
    do_req(1, 1, 32'h108, 32'h1234_5678, 3'b010, -1, -1);
    do_req(1, 0, 32'h108, 32'h0, 3'b010, -1, -1);

    no_resp = 1'b1;
    do_req(1, 0, 32'h10C, 32'h0, 3'b010, -1, 17);
    chk("timeout_strobe_cycles", 128'(strobe_cycles),
        128'(16));
    no_resp = 1'b0;

    do_req(0, 1, 32'h110, 32'hCAFE_F00D, 3'b010, 0, 2);
    stray_req = 1'b1;
    do_req(1, 0, 32'h110, 32'h0, 3'b010, 0, 2);
    stray_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_quiet",
        128'({mem_resp, p.pmem_read, p.pmem_write}),
        128'(0));

    // Abort an access in flight with reset.
    no_resp = 1'b1;
    exp_waddr = 32'h118;
    exp_is_wr = 1'b0;
    exp_be = 4'hf;
    rsp_dly = 0;
    @(posedge clk);
    #1;
    mem_address = 32'h118;
    mem_funct3 = 3'b010;
    mem_read = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("strobe_before_rst", 128'(p.pmem_read), 128'(1));
    rst = 1'b1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_outputs",
        128'({mem_resp, mem_err, mem_rdata, rmask, wmask,
              p.pmem_read, p.pmem_write, p.pmem_address,
              p.pmem_wdata, p.pmem_byte_enable}),
        128'(0));
    rst = 1'b0;
    no_resp = 1'b0;
    repeat (3) @(posedge clk);
    do_req(1, 0, 32'h118, 32'h0, 3'b010, -1, -1);

    for (int k = 0; k < 80; k++) begin
      kind = $urandom_range(0, 2);
      do_req(kind != 1, kind != 0,
             32'h100 + 32'($urandom_range(0, 63)),
             $urandom, 3'($urandom_range(0, 7)), -1, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
